// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transmit and receive paths.
// Optional feature macro used by this slice: SPI_TX_UNDERRUN_CNT_EN.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    WAIT_REQ,
    WAIT_DROP
  } spi_tx_state_e;

  // Saturating increment for 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_slave_tx_if.sv
// Byte handshake bundle between the clk_sys sender and the SPI transmit path.
// underrun_cnt exists only when SPI_TX_UNDERRUN_CNT_EN is defined.
interface spi_slave_tx_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_req;
  logic              tx_ack;
  logic              tx_busy;
  logic              underrun;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0]        underrun_cnt;

  modport master (
    output tx_data, tx_req,
    input  tx_ack, tx_busy, underrun, underrun_cnt
  );

  modport slave (
    input  tx_data, tx_req,
    output tx_ack, tx_busy, underrun, underrun_cnt
  );
`else
  modport master (
    output tx_data, tx_req,
    input  tx_ack, tx_busy, underrun
  );

  modport slave (
    input  tx_data, tx_req,
    output tx_ack, tx_busy, underrun
  );
`endif

endinterface

// File: rtl/spi_sync_bit.sv
// N-flop single-bit synchroniser, reset to 0; shared by the SPI tx and rx crossings.
module spi_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave MISO path: 4-phase byte handshake into a single holding buffer, shifted out MSB-first.
// Define SPI_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = {DATA_W{1'b1}}
) (
  input  logic                 spi_clk,
  input  logic                 rst,
  output logic                 spi_miso,
  spi_slave_tx_if.slave        tx
);

  localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_buf;
  logic              hold_valid;
  logic              underrun_q;
  logic              ack_q;
  logic              ack_next;
  logic              req_s;
  logic              boundary;
  logic              capture;
  spi_tx_state_e     state;
  spi_tx_state_e     state_next;

  spi_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (spi_clk),
    .rst (rst),
    .d   (tx.tx_req),
    .q   (req_s)
  );

  assign boundary = (bit_cnt == LAST_BIT);

  // The buffer counts as free on the boundary edge, since its byte moves into shift_reg then.
  always_comb begin
    state_next = state;
    ack_next   = ack_q;
    capture    = 1'b0;
    case (state)
      WAIT_REQ: begin
        if (req_s && (!hold_valid || boundary)) begin
          capture    = 1'b1;
          ack_next   = 1'b1;
          state_next = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!req_s) begin
          ack_next   = 1'b0;
          state_next = WAIT_REQ;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = WAIT_REQ;
      end
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state <= WAIT_REQ;
      ack_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= ack_next;
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_reg  <= IDLE_BYTE;
      hold_buf   <= '0;
      hold_valid <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= boundary & ~hold_valid;
      if (boundary) begin
        bit_cnt   <= '0;
        shift_reg <= hold_valid ? hold_buf : IDLE_BYTE;
      end else begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      end
      if (capture) begin
        hold_buf   <= tx.tx_data;
        hold_valid <= 1'b1;
      end else if (boundary) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt_q;

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      underrun_cnt_q <= '0;
    end else if (underrun_q) begin
      underrun_cnt_q <= sat_inc8(underrun_cnt_q);
    end
  end

  assign tx.underrun_cnt = underrun_cnt_q;
`endif

  assign spi_miso   = shift_reg[DATA_W-1];
  assign tx.tx_ack  = ack_q;
  assign tx.tx_busy = hold_valid;
  assign tx.underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Self-checking bench for spi_slave_tx: frame-level reference model plus directed literal checks.
// Honours SPI_TX_UNDERRUN_CNT_EN when the bundle is built with it.
module tb_spi_slave_tx;
  import spi_pkg::*;

  localparam int         DATA_W = SPI_DATA_W;
  localparam int         SYNC   = SPI_SYNC_STAGES;
  localparam logic [7:0] IDLE   = 8'hFF;

  logic spi_clk = 1'b0;
  logic rst     = 1'b1;
  logic spi_miso;

  int assertions = 0;
  int failures   = 0;

  spi_slave_tx_if #(.DATA_W(DATA_W)) tx_bus ();

  spi_slave_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC),
    .IDLE_BYTE   (IDLE)
  ) dut (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .spi_miso (spi_miso),
    .tx       (tx_bus)
  );

  always #5 spi_clk = ~spi_clk;

  // Reference model: the byte currently on the wire plus bit position, one buffered byte,
  // and the request seen through a SYNC-deep delay line.
  logic [7:0]      m_cur   = IDLE;
  logic [7:0]      m_hold  = '0;
  int              m_pos   = 0;
  bit              m_full  = 0;
  bit              m_ack   = 0;
  bit              m_drop  = 0;
  bit              m_ur    = 0;
  int              m_cnt   = 0;
  bit [SYNC-1:0]   m_pipe  = '0;
  bit              m_valid = 0;
  int              edges   = 0;

  always @(posedge spi_clk) begin : model
    logic [7:0] cur, hold;
    int         pos, cnt;
    bit         full, ack, drop, req_seen, last_bit;
    if (rst) begin
      m_cur   <= IDLE;
      m_hold  <= '0;
      m_pos   <= 0;
      m_full  <= 0;
      m_ack   <= 0;
      m_drop  <= 0;
      m_ur    <= 0;
      m_cnt   <= 0;
      m_pipe  <= '0;
      m_valid <= 1;
      edges   <= 0;
    end else begin
      cur      = m_cur;
      hold     = m_hold;
      pos      = m_pos;
      full     = m_full;
      ack      = m_ack;
      drop     = m_drop;
      cnt      = m_cnt;
      req_seen = m_pipe[SYNC-1];
      last_bit = (m_pos == DATA_W - 1);
      if (m_ur && cnt < 255) cnt++;
      if (last_bit) begin
        cur  = full ? hold : IDLE;
        full = 0;
        pos  = 0;
      end else begin
        pos++;
      end
      if (!drop && req_seen && (!m_full || last_bit)) begin
        hold = tx_bus.tx_data;
        full = 1;
        ack  = 1;
        drop = 1;
      end else if (drop && !req_seen) begin
        ack  = 0;
        drop = 0;
      end
      m_cur  <= cur;
      m_hold <= hold;
      m_pos  <= pos;
      m_full <= full;
      m_ack  <= ack;
      m_drop <= drop;
      m_ur   <= last_bit && !m_full;
      m_cnt  <= cnt;
      m_pipe <= {m_pipe[SYNC-2:0], tx_bus.tx_req};
      edges  <= edges + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expected);
    assertions++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, expected, $time);
    end
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge spi_clk) begin
    if (m_valid) begin
      checkOutput("model_miso", spi_miso, m_cur[DATA_W-1-m_pos]);
      checkOutput("model_ack", tx_bus.tx_ack, m_ack);
      checkOutput("model_busy", tx_bus.tx_busy, m_full);
      checkOutput("model_underrun", tx_bus.underrun, m_ur);
`ifdef SPI_TX_UNDERRUN_CNT_EN
      checkOutput("model_underrun_cnt", tx_bus.underrun_cnt, 32'(m_cnt));
`endif
    end
  end

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(negedge spi_clk);
    rst = 1'b0;
  endtask

  task automatic waitEdge(input int n);
    int budget = 0;
    while (edges < n && budget < 5000) begin
      @(negedge spi_clk);
      budget++;
    end
    if (edges < n) checkOutput("edge_wait_timeout", edges, n);
  endtask

  task automatic waitAck(input logic level, input int budget, input string name);
    int n = 0;
    while (tx_bus.tx_ack !== level && n < budget) begin
      @(negedge spi_clk);
      n++;
    end
    checkOutput(name, tx_bus.tx_ack, level);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    tx_bus.tx_data = data;
    tx_bus.tx_req  = 1'b1;
    waitAck(1'b1, 64, "rand_ack_rise");
    tx_bus.tx_req  = 1'b0;
    waitAck(1'b0, 64, "rand_ack_fall");
  endtask

  // 3C captured at edge 9, C3 requested after its ack drops; extra delays the second request.
  task automatic backToBack(input int extra);
    logic [7:0] first  = 8'h3C;
    logic [7:0] second = 8'hC3;
    logic [7:0] frame;
    doReset();
    waitEdge(6);
    tx_bus.tx_data = first;
    tx_bus.tx_req  = 1'b1;
    waitAck(1'b1, 20, "b2b_first_ack");
    checkOutput("b2b_first_ack_edge", edges, 9);
    tx_bus.tx_req = 1'b0;
    waitAck(1'b0, 20, "b2b_first_drop");
    checkOutput("b2b_first_drop_edge", edges, 12);
    waitEdge(12 + extra);
    tx_bus.tx_data = second;
    tx_bus.tx_req  = 1'b1;
    waitEdge(15);
    checkOutput("b2b_ack_withheld", tx_bus.tx_ack, 1'b0);
    waitEdge(16);
    checkOutput("b2b_second_ack_at_boundary", tx_bus.tx_ack, 1'b1);
    checkOutput("b2b_busy_at_boundary", tx_bus.tx_busy, 1'b1);
    tx_bus.tx_req = 1'b0;
    for (int e = 16; e < 32; e++) begin
      waitEdge(e);
      frame = (e < 24) ? first : second;
      checkOutput("b2b_miso", spi_miso, frame[7 - (e % 8)]);
      if (e % 8 == 0) checkOutput("b2b_no_underrun", tx_bus.underrun, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    tx_bus.tx_req  = 1'b0;
    tx_bus.tx_data = '0;

    $display("[TB] test 1: reset and idle frames");
    doReset();
    checkOutput("t1_reset_miso", spi_miso, 1'b1);
    checkOutput("t1_reset_ack", tx_bus.tx_ack, 1'b0);
    checkOutput("t1_reset_busy", tx_bus.tx_busy, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      @(negedge spi_clk);
      checkOutput("t1_idle_miso", spi_miso, 1'b1);
      checkOutput("t1_underrun", tx_bus.underrun, (n == 8 || n == 16) ? 1'b1 : 1'b0);
    end

    $display("[TB] test 2: single byte A5");
    doReset();
    pat = 8'hA5;
    tx_bus.tx_data = pat;
    tx_bus.tx_req  = 1'b1;
    waitAck(1'b1, 20, "t2_ack_rise");
    checkOutput("t2_ack_latency", edges, 3);
    checkOutput("t2_busy_after_ack", tx_bus.tx_busy, 1'b1);
    tx_bus.tx_req = 1'b0;
    waitAck(1'b0, 20, "t2_ack_fall");
    checkOutput("t2_ack_drop_edge", edges, 6);
    for (int e = 8; e < 16; e++) begin
      waitEdge(e);
      checkOutput("t2_miso", spi_miso, pat[15 - e]);
      if (e == 8) begin
        checkOutput("t2_no_underrun", tx_bus.underrun, 1'b0);
        checkOutput("t2_busy_after_load", tx_bus.tx_busy, 1'b0);
      end
    end

    $display("[TB] test 3: back-to-back bytes");
    backToBack(0);
    $display("[TB] test 4: request landing on the boundary edge");
    backToBack(1);

    $display("[TB] test 5: reset mid-frame");
    doReset();
    tx_bus.tx_data = 8'hF0;
    tx_bus.tx_req  = 1'b1;
    waitAck(1'b1, 20, "t5_f0_ack");
    tx_bus.tx_req = 1'b0;
    waitAck(1'b0, 20, "t5_f0_drop");
    waitEdge(6);
    tx_bus.tx_data = 8'h0F;
    tx_bus.tx_req  = 1'b1;
    waitAck(1'b1, 20, "t5_0f_ack");
    tx_bus.tx_req = 1'b0;
    waitAck(1'b0, 20, "t5_0f_drop");
    waitEdge(12);
    checkOutput("t5_held_busy", tx_bus.tx_busy, 1'b1);
    tx_bus.tx_data = 8'h5A;
    tx_bus.tx_req  = 1'b1;
    rst = 1'b1;
    @(negedge spi_clk);
    checkOutput("t5_rst_ack", tx_bus.tx_ack, 1'b0);
    checkOutput("t5_rst_busy", tx_bus.tx_busy, 1'b0);
    repeat (2) @(negedge spi_clk);
    rst = 1'b0;
    checkOutput("t5_post_rst_miso", spi_miso, 1'b1);
    waitAck(1'b1, 20, "t5_reack");
    checkOutput("t5_reack_edge", edges, 3);
    tx_bus.tx_req = 1'b0;
    pat = 8'h5A;
    for (int e = 4; e < 16; e++) begin
      waitEdge(e);
      checkOutput("t5_miso", spi_miso, (e < 8) ? 1'b1 : pat[15 - e]);
    end
    waitAck(1'b0, 20, "t5_reack_drop");

`ifdef SPI_TX_UNDERRUN_CNT_EN
    $display("[TB] test 6: underrun counter saturation");
    doReset();
    waitEdge(9);
    checkOutput("t6_cnt_first", tx_bus.underrun_cnt, 8'd1);
    waitEdge(8 * 300);
    checkOutput("t6_cnt_saturated", tx_bus.underrun_cnt, 8'hFF);
`endif

    $display("[TB] random phase");
    doReset();
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge spi_clk);
      applyStimulus(8'($urandom));
    end
    repeat (20) @(negedge spi_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
